// File: rtl/checksum_check_if.sv
// Header-word handshake and result bundle for checksum_check.
// master = header source, slave = checksum checker.
`timescale 1ns/1ps
interface checksum_check_if;
  logic        req;
  logic [4:0]  hdr_words;
  logic [15:0] word_in;
  logic        word_valid;
  logic        rdy;
  logic        gnt;
  logic        ok;
  logic        err_len;
  logic [15:0] new_checksum;

  modport master (
    output req, hdr_words, word_in, word_valid,
    input  rdy, gnt, ok, err_len, new_checksum
  );

  modport slave (
    input  req, hdr_words, word_in, word_valid,
    output rdy, gnt, ok, err_len, new_checksum
  );
endinterface

// File: rtl/checksum_check.sv
// Internet-style one's complement header checksum verifier (IDLE/ACCUM/FOLD1/FOLD2/DONE).
// Define CHECKSUM_CHECK_LEN_EN to restrict hdr_words to the IPv4 range 10..30.
`timescale 1ns/1ps
module checksum_check (
  input  logic           clk,
  input  logic           reset,
  checksum_check_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] FOLD1 = 3'd2;
  localparam logic [2:0] FOLD2 = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [4:0]  len_q;
  logic [4:0]  count;
  logic [20:0] acc;
  logic [16:0] s17;
  logic [15:0] s16;
  logic        err_q;
  logic        gnt_q;
  logic        ok_q;
  logic        err_len_q;
  logic [15:0] csum_q;
  logic        legal;

`ifdef CHECKSUM_CHECK_LEN_EN
  assign legal = (bus.hdr_words >= 5'd10) && (bus.hdr_words <= 5'd30);
`else
  assign legal = (bus.hdr_words != 5'd0);
`endif

  // Results are registered in DONE so gnt lands three edges after the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      acc       <= '0;
      s17       <= '0;
      s16       <= '0;
      err_q     <= 1'b0;
      gnt_q     <= 1'b0;
      ok_q      <= 1'b0;
      err_len_q <= 1'b0;
      csum_q    <= '0;
    end else begin
      gnt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (legal) begin
              len_q <= bus.hdr_words;
              acc   <= '0;
              count <= '0;
              err_q <= 1'b0;
              state <= ACCUM;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (bus.word_valid) begin
            acc   <= acc + {5'd0, bus.word_in};
            count <= count + 5'd1;
            if ((count + 5'd1) == len_q)
              state <= FOLD1;
          end
        end
        FOLD1: begin
          s17   <= {1'b0, acc[15:0]} + {12'd0, acc[20:16]};
          state <= FOLD2;
        end
        FOLD2: begin
          s16   <= s17[15:0] + {15'd0, s17[16]};
          state <= DONE;
        end
        DONE: begin
          gnt_q     <= 1'b1;
          err_len_q <= err_q;
          if (err_q) begin
            ok_q   <= 1'b0;
            csum_q <= 16'h0000;
          end else begin
            ok_q   <= (s16 == 16'hFFFF);
            csum_q <= ~s16;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdy          = (state == ACCUM);
  assign bus.gnt          = gnt_q;
  assign bus.ok           = ok_q;
  assign bus.err_len      = err_len_q;
  assign bus.new_checksum = csum_q;
endmodule

// File: tb/tb_checksum_check.sv
// Directed scoreboard bench for checksum_check; expected results come from a
// per-word end-around-carry model and are popped when gnt arrives.
`timescale 1ns/1ps
module tb_checksum_check;
  typedef logic [15:0] hdr_t [32];
  typedef struct packed {
    logic        ok;
    logic        err_len;
    logic [15:0] csum;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  checksum_check_if bus ();

  checksum_check dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gnt_seen = 0;
  hdr_t good, bad, len4, allf, none;

  always @(posedge bus.gnt) gnt_seen++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isLegal(input int n);
`ifdef CHECKSUM_CHECK_LEN_EN
    return (n >= 10) && (n <= 30);
`else
    return (n >= 1) && (n <= 31);
`endif
  endfunction

  // One's complement sum with the carry wrapped after every word.
  function automatic logic [15:0] onesSum(input hdr_t w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      s = s + int'(w[i]);
      if (s > 65535) s = s - 65535;
    end
    return s[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int n, input hdr_t w, input bit gapped);
    exp_t        e;
    bit          legal;
    int          start_g;
    int          lat;
    logic [15:0] s;
    legal     = isLegal(n);
    s         = onesSum(w, n);
    e.err_len = !legal;
    e.ok      = legal && (s == 16'hFFFF);
    e.csum    = legal ? ~s : 16'h0000;
    sb.push_back(e);
    start_g = gnt_seen;
    bus.req = 1'b1;
    bus.hdr_words = n[4:0];
    bus.word_valid = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    if (legal) begin
      checkOutput("rdy_after_req", {31'd0, bus.rdy}, 32'd1);
      for (int i = 0; i < n; i++) begin
        if (gapped) begin
          // An illegal-length req while busy must be ignored, not queued.
          bus.word_valid = 1'b0;
          bus.req = 1'b1;
          bus.hdr_words = 5'd0;
          @(negedge clk);
          bus.req = 1'b0;
        end
        bus.word_in = w[i];
        bus.word_valid = 1'b1;
        @(negedge clk);
      end
      bus.word_valid = 1'b0;
      checkOutput("rdy_drop", {31'd0, bus.rdy}, 32'd0);
    end else begin
      checkOutput("rdy_illegal", {31'd0, bus.rdy}, 32'd0);
    end
    lat = 0;
    while (bus.gnt !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!legal && bus.rdy === 1'b1)
        checkOutput("rdy_never_illegal", {31'd0, bus.rdy}, 32'd0);
    end
    checkOutput("gnt_latency", lat, legal ? 32'd3 : 32'd1);
    if (bus.gnt === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("ok", {31'd0, bus.ok}, {31'd0, e.ok});
      checkOutput("err_len", {31'd0, bus.err_len}, {31'd0, e.err_len});
      checkOutput("new_checksum", {16'd0, bus.new_checksum}, {16'd0, e.csum});
    end else begin
      checkOutput("gnt_timeout", {31'd0, bus.gnt}, 32'd1);
    end
    @(negedge clk);
    checkOutput("gnt_pulse", {31'd0, bus.gnt}, 32'd0);
    checkOutput("ok_hold", {31'd0, bus.ok}, {31'd0, e.ok});
    checkOutput("csum_hold", {16'd0, bus.new_checksum}, {16'd0, e.csum});
    checkOutput("gnt_count", gnt_seen - start_g, 32'd1);
  endtask

  initial begin
    int g;
    good = '{default: 16'h0000};
    good[0] = 16'h4500; good[1] = 16'h0073; good[2] = 16'h0000; good[3] = 16'h4000;
    good[4] = 16'h4011; good[5] = 16'hB861; good[6] = 16'hC0A8; good[7] = 16'h0001;
    good[8] = 16'hC0A8; good[9] = 16'h00C7;
    bad = good;
    bad[5] = 16'hB862;
    len4 = '{default: 16'h0000};
    len4[0] = 16'hFFFF;
    allf = '{default: 16'hFFFF};
    none = '{default: 16'h0000};

    reset = 1'b0;
    bus.req = 1'b0;
    bus.hdr_words = 5'd0;
    bus.word_in = 16'h0000;
    bus.word_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdy", {31'd0, bus.rdy}, 32'd0);
    checkOutput("reset_gnt", {31'd0, bus.gnt}, 32'd0);
    checkOutput("reset_ok", {31'd0, bus.ok}, 32'd0);
    checkOutput("reset_err_len", {31'd0, bus.err_len}, 32'd0);
    checkOutput("reset_csum", {16'd0, bus.new_checksum}, 32'd0);

    $display("[TB] good header, req on first edge after reset");
    reset = 1'b1;
    applyStimulus(10, good, 1'b0);

    $display("[TB] word_valid alone in IDLE");
    g = gnt_seen;
    bus.word_in = 16'hFFFF;
    bus.word_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_rdy", {31'd0, bus.rdy}, 32'd0);
    bus.word_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_no_gnt", gnt_seen - g, 32'd0);

    $display("[TB] length 4 and length 0");
    applyStimulus(4, len4, 1'b0);
    applyStimulus(0, none, 1'b0);

    $display("[TB] gapped good header with busy req pulses");
    applyStimulus(10, good, 1'b1);

    $display("[TB] corrupt header");
    applyStimulus(10, bad, 1'b0);

    $display("[TB] reset mid-header");
    g = gnt_seen;
    bus.req = 1'b1;
    bus.hdr_words = 5'd10;
    @(negedge clk);
    bus.req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.word_in = good[i];
      bus.word_valid = 1'b1;
      @(negedge clk);
    end
    bus.word_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rdy", {31'd0, bus.rdy}, 32'd0);
    checkOutput("async_ok", {31'd0, bus.ok}, 32'd0);
    checkOutput("async_csum", {16'd0, bus.new_checksum}, 32'd0);
    checkOutput("async_err_len", {31'd0, bus.err_len}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("reset_no_gnt", gnt_seen - g, 32'd0);
    applyStimulus(10, good, 1'b0);

    $display("[TB] max length all-ones");
    applyStimulus(31, allf, 1'b0);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/checksum_check.md
CHECKSUM_CHECK -- requirements
Module: checksum_check

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-003 Port req, input, 1: start-of-header request; sampled only in IDLE.
REQ-004 Port hdr_words, input, 5: number of 16-bit header words to check; sampled with req.
REQ-005 Port word_in, input, 16: header word, big-endian order as received.
REQ-006 Port word_valid, input, 1: word_in valid; word accepted when word_valid and rdy are both 1.
REQ-007 Port rdy, output, 1: block accepts header words; high only in ACCUM.
REQ-008 Port gnt, output, 1: one-cycle pulse; result outputs valid in the same cycle.
REQ-009 Port ok, output, 1: 1 = header checksum correct (folded sum == 16'hFFFF).
REQ-010 Port err_len, output, 1: 1 = request rejected for illegal hdr_words.
REQ-011 Port new_checksum, output, 16: one's complement of the folded sum; 16'h0000 for a good header.

Function
REQ-012 States SHALL be IDLE, ACCUM, FOLD1, FOLD2, DONE.
REQ-013 IDLE: on req=1 with legal hdr_words, latch hdr_words, clear the 21-bit accumulator and word counter, go to ACCUM.
REQ-014 IDLE: req=0 or word_valid alone SHALL cause no state change.
REQ-015 ACCUM: each accepted word SHALL be added zero-extended into the 21-bit accumulator; counter increments.
REQ-016 ACCUM: the cycle accepting word number hdr_words SHALL move to FOLD1; rdy drops the next cycle.
REQ-017 ACCUM with word_valid=0 SHALL hold state indefinitely (no timeout).
REQ-018 FOLD1: s17 = acc[15:0] + acc[20:16], 17 bits.
REQ-019 FOLD2: s16 = s17[15:0] + s17[16], 16 bits; no carry is possible out of this stage.
REQ-020 DONE: gnt=1 for exactly one cycle, ok = (s16 == 16'hFFFF), new_checksum = ~s16, err_len=0, then go to IDLE.
REQ-021 Latency SHALL be gnt exactly 3 cycles after the rising edge that accepts the last word.
REQ-022 req asserted in any state other than IDLE SHALL be ignored; it is not queued.
REQ-023 ok, err_len and new_checksum SHALL hold their values until the next gnt.
REQ-024 hdr_words=0 SHALL be illegal in all builds.
REQ-025 An illegal request SHALL go IDLE->DONE, giving gnt with ok=0, err_len=1, new_checksum=16'h0000, and accept no words.
REQ-026 The accumulator SHALL never overflow: 31 x 16'hFFFF < 2^21.

Reset
REQ-027 With reset=0, the block SHALL go to IDLE immediately, asynchronously.
REQ-028 With reset=0, rdy, gnt, ok and err_len SHALL be 0, new_checksum 16'h0000, and the accumulator and counter 0.
REQ-029 Reset asserted mid-header SHALL discard the partial sum and produce no gnt.
REQ-030 The first req SHALL be honoured on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro CHECKSUM_CHECK_LEN_EN SHALL select the legal range of hdr_words.
REQ-032 With CHECKSUM_CHECK_LEN_EN defined, legal hdr_words SHALL be 10..30 (IPv4 IHL 5..15); all other values are illegal per REQ-025.
REQ-033 With CHECKSUM_CHECK_LEN_EN undefined, legal hdr_words SHALL be 1..31; only 0 is illegal.

Verification
REQ-034 Good header: req with hdr_words=10, then words 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7 -> gnt 3 cycles after the last word, ok=1, new_checksum=0000.
REQ-035 Corrupt header: the same words with B861 replaced by B862 -> ok=0, new_checksum=FFFE, err_len=0.
REQ-036 Length check: with CHECKSUM_CHECK_LEN_EN defined, hdr_words=4 -> gnt with ok=0, err_len=1 and rdy never high; with the macro undefined, hdr_words=4 with words FFFF 0000 0000 0000 -> ok=1.
REQ-037 Gapped input: word_valid toggled every other cycle over the good header -> same result as REQ-034; req pulses while busy are ignored.
REQ-038 Reset mid-header: reset=0 after 5 words -> outputs cleared immediately, no gnt; a following good header -> ok=1.
REQ-039 Max length: hdr_words=31 with all words FFFF (no length check) -> ok=1, new_checksum=0000, no overflow.
